// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant, binary index,
// and an optional hold-timeout that forces the owner to release the resource.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  input  logic       DONE,
  output logic [3:0] GNT,
  output logic [1:0] ENC,
  output logic       VLD,
  output logic       TMO
);

  localparam bit          TMO_EN    = (MAX_HOLD != 0);
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q;
  logic [1:0]    ptr_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    gnt_q;
  logic [1:0]    enc_q;
  logic          vld_q;
  logic          tmo_q;

  // Requests rotated so that bit 0 is the requester the pointer currently favours.
  logic [3:0] rot_req;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_req[gi] = REQ[ptr_q + 2'(gi)];
    end
  endgenerate

  logic [1:0] win_ofs;
  logic [1:0] win_idx;
  always_comb begin
    win_ofs = 2'd0;
    if (rot_req[0])      win_ofs = 2'd0;
    else if (rot_req[1]) win_ofs = 2'd1;
    else if (rot_req[2]) win_ofs = 2'd2;
    else if (rot_req[3]) win_ofs = 2'd3;
  end
  assign win_idx = ptr_q + win_ofs;

  logic soft_rel;
  logic hold_exp;
  assign soft_rel = DONE | ~REQ[enc_q];
  assign hold_exp = TMO_EN && (cnt_q == HOLD_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      enc_q   <= 2'd0;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|REQ) begin
            gnt_q   <= 4'b0001 << win_idx;
            enc_q   <= win_idx;
            vld_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (soft_rel || hold_exp) begin
            // An explicit release or withdraw masks the timeout indication.
            tmo_q   <= hold_exp && !soft_rel;
            ptr_q   <= enc_q + 2'd1;
            gnt_q   <= 4'b0000;
            enc_q   <= 2'd0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign GNT = gnt_q;
  assign ENC = enc_q;
  assign VLD = vld_q;
  assign TMO = tmo_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with MAX_HOLD=4; outputs are checked as
// the packed vector {TMO, VLD, ENC[1:0], GNT[3:0]} one step after each edge.
module tb_rr_arbiter4;

  logic       CLK;
  logic       RST;
  logic [3:0] REQ;
  logic       DONE;
  logic [3:0] GNT;
  logic [1:0] ENC;
  logic       VLD;
  logic       TMO;

  int total_cnt = 0;
  int bad_cnt   = 0;

  rr_arbiter4 #(.MAX_HOLD(4), .CW(8)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .REQ  (REQ),
    .DONE (DONE),
    .GNT  (GNT),
    .ENC  (ENC),
    .VLD  (VLD),
    .TMO  (TMO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end else begin
      $display("ok   %s: %b", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input string tag, input logic [7:0] exp);
    tick();
    chk(tag, {TMO, VLD, ENC, GNT}, exp);
  endtask

  // Structural invariants, sampled mid-cycle once reset has been released.
  logic inv_en = 1'b0;
  always @(negedge CLK) begin
    if (inv_en) begin
      chk("inv_onehot", 8'($onehot0(GNT)), 8'd1);
      chk("inv_vld", 8'(VLD), 8'(|GNT));
      if (!VLD) chk("inv_enc0", 8'(ENC), 8'd0);
    end
  end

  initial begin
    RST = 1'b1; REQ = 4'b0000; DONE = 1'b0;
    step("reset", 8'b0_0_00_0000);
    RST = 1'b0;
    inv_en = 1'b1;
    for (int i = 0; i < 5; i++) step("idle_noreq", 8'b0_0_00_0000);

    // Fairness with REQ=0101 held
    REQ = 4'b0101;
    step("fair_g0", 8'b0_1_00_0001);
    DONE = 1'b1; step("fair_rel0", 8'b0_0_00_0000);
    DONE = 1'b0; step("fair_g2", 8'b0_1_10_0100);
    DONE = 1'b1; step("fair_rel2", 8'b0_0_00_0000);
    DONE = 1'b0; step("fair_g0_again", 8'b0_1_00_0001);
    DONE = 1'b1; step("fair_rel0_again", 8'b0_0_00_0000);

    // Wrap-around after a grant to requester 3
    REQ = 4'b1000; DONE = 1'b0; step("wrap_g3", 8'b0_1_11_1000);
    DONE = 1'b1; step("wrap_rel3", 8'b0_0_00_0000);
    REQ = 4'b1001; DONE = 1'b0; step("wrap_g0", 8'b0_1_00_0001);
    DONE = 1'b1; step("wrap_rel0", 8'b0_0_00_0000);

    // Timeout: four grant cycles, one TMO pulse, then regrant
    REQ = 4'b0010; DONE = 1'b0;
    step("tmo_hold1", 8'b0_1_01_0010);
    step("tmo_hold2", 8'b0_1_01_0010);
    step("tmo_hold3", 8'b0_1_01_0010);
    step("tmo_hold4", 8'b0_1_01_0010);
    step("tmo_pulse", 8'b1_0_00_0000);
    step("tmo_regrant", 8'b0_1_01_0010);

    // Owner withdraws: release without TMO
    REQ = 4'b0000; step("withdraw_rel", 8'b0_0_00_0000);
    step("withdraw_idle", 8'b0_0_00_0000);

    // DONE on the timeout cycle: release without TMO
    REQ = 4'b0010;
    step("dtmo_g1", 8'b0_1_01_0010);
    step("dtmo_h2", 8'b0_1_01_0010);
    step("dtmo_h3", 8'b0_1_01_0010);
    step("dtmo_h4", 8'b0_1_01_0010);
    DONE = 1'b1; step("dtmo_rel", 8'b0_0_00_0000);
    DONE = 1'b0; REQ = 4'b0000; step("dtmo_idle", 8'b0_0_00_0000);

    // Reset mid-grant, then pointer restarts at 0
    REQ = 4'b1000; step("rst_g3", 8'b0_1_11_1000);
    RST = 1'b1; step("rst_mid", 8'b0_0_00_0000);
    RST = 1'b0; REQ = 4'b1010; step("rst_ptr0", 8'b0_1_01_0010);
    DONE = 1'b1; step("rst_rel", 8'b0_0_00_0000);
    DONE = 1'b0; REQ = 4'b0000;
    tick();

    inv_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
